// File: rtl/count_bits_seq.sv
// count_bits_seq: sequential zero/one counter, BPC bits per clock; COUNT_LZ_EN adds a leading-zero count output.
module count_bits_seq #(
  parameter int DATA_W = 8,
  parameter int BPC    = 1,
  localparam int CW    = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef COUNT_LZ_EN
  output logic [CW-1:0]     out_lz,
`endif
  output logic [CW-1:0]     out_count
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mode_q, mode_d;
  logic [CW-1:0]     cnt_q, cnt_d, idx_q, idx_d;
`ifdef COUNT_LZ_EN
  logic [CW-1:0]     lz_q, lz_d;
`endif
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
`ifdef COUNT_LZ_EN
    lz_d    = lz_q;
`endif
    unique case (state_q)
      IDLE: if (in_valid) begin
        data_d  = in_data;
        mode_d  = in_mode;
        cnt_d   = '0;
        idx_d   = '0;
`ifdef COUNT_LZ_EN
        lz_d    = CW'(DATA_W);
`endif
        state_d = SCAN;
      end
      SCAN: begin
        // data_q shifts right so the current chunk always sits at bit 0; idx_q tracks its true position
        data_d = data_q >> BPC;
        idx_d  = idx_q + CW'(BPC);
        for (int b = 0; b < BPC; b++) begin
          if (data_q[b] == mode_q) cnt_d = cnt_d + 1'b1;
`ifdef COUNT_LZ_EN
          if (data_q[b]) lz_d = CW'(DATA_W - 1 - b) - idx_q;
`endif
        end
        state_d = (idx_d == CW'(DATA_W)) ? DONE : SCAN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef COUNT_LZ_EN
      lz_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef COUNT_LZ_EN
      lz_q    <= lz_d;
`endif
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_count = out_valid ? cnt_q : '0;
`ifdef COUNT_LZ_EN
  assign out_lz    = out_valid ? lz_q : '0;
`endif
endmodule

// File: tb/tb_count_bits_seq.sv
// tb_count_bits_seq: random and directed checks of count_bits_seq (8x1 and 16x4) against a bit-counting reference.
module tb_count_bits_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv8 = 1'b0, m8 = 1'b0, or8 = 1'b0, ir8, ov8;
  logic [7:0] d8 = '0;
  logic [3:0] c8, lz8;
  logic iv16 = 1'b0, m16 = 1'b0, or16 = 1'b0, ir16, ov16;
  logic [15:0] d16 = '0;
  logic [4:0] c16, lz16;
  logic sel = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  count_bits_seq #(.DATA_W(8), .BPC(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(d8), .in_mode(m8),
    .out_valid(ov8), .out_ready(or8),
`ifdef COUNT_LZ_EN
    .out_lz(lz8),
`endif
    .out_count(c8));
  count_bits_seq #(.DATA_W(16), .BPC(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_data(d16), .in_mode(m16),
    .out_valid(ov16), .out_ready(or16),
`ifdef COUNT_LZ_EN
    .out_lz(lz16),
`endif
    .out_count(c16));
`ifndef COUNT_LZ_EN
  assign lz8 = '0;
  assign lz16 = '0;
`endif
  logic rdy_obs, vld_obs;
  logic [63:0] cnt_obs, lz_obs;
  assign rdy_obs = sel ? ir16 : ir8;
  assign vld_obs = sel ? ov16 : ov8;
  assign cnt_obs = sel ? 64'(c16) : 64'(c8);
  assign lz_obs  = sel ? 64'(lz16) : 64'(lz8);
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic void ref_model(input logic [15:0] d, input bit m, input int w,
                                    output logic [63:0] c, output logic [63:0] lz);
    c = 0;
    lz = 0;
    for (int i = 0; i < w; i++) if (d[i] == m) c++;
    for (int i = w - 1; i >= 0; i--) begin
      if (d[i]) break;
      lz++;
    end
  endfunction
  task automatic accept(input bit s, input logic [15:0] d, input bit m);
    int t;
    sel = s;
    t = 0;
    while (!rdy_obs && t < 40) begin @(negedge clk); t++; end
    check("in_ready_idle", 64'(rdy_obs), 64'd1);
    if (s) begin iv16 = 1'b1; d16 = d; m16 = m; end
    else begin iv8 = 1'b1; d8 = d[7:0]; m8 = m; end
    @(negedge clk);
    iv8 = 1'b0; iv16 = 1'b0;
    d8 = 8'($urandom); d16 = 16'($urandom); m8 = 1'($urandom); m16 = 1'($urandom);
    check("in_ready_busy", 64'(rdy_obs), 64'd0);
  endtask
  task automatic run(input bit s, input logic [15:0] d, input bit m, input int hold);
    int n, lat;
    logic [63:0] ec, el;
    n = s ? 4 : 8;
    ref_model(d, m, s ? 16 : 8, ec, el);
    accept(s, d, m);
    lat = 0;
    while (!vld_obs && lat <= 3 * n) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'(n));
    check("count", cnt_obs, ec);
`ifdef COUNT_LZ_EN
    check("lz", lz_obs, el);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_count", cnt_obs, ec);
      check("hold_in_ready", 64'(rdy_obs), 64'd0);
      check("hold_valid", 64'(vld_obs), 64'd1);
    end
    if (s) or16 = 1'b1; else or8 = 1'b1;
    @(negedge clk);
    or8 = 1'b0; or16 = 1'b0;
    check("post_valid", 64'(vld_obs), 64'd0);
    check("post_in_ready", 64'(rdy_obs), 64'd1);
    check("post_count", cnt_obs, 64'd0);
  endtask
  task automatic reset_mid(input bit s, input int wait_cyc);
    int seen;
    accept(s, 16'hA5C3, 1'b1);
    for (int i = 0; i < wait_cyc; i++) @(negedge clk);
    rst = 1'b1;
    if (s) or16 = 1'b1; else or8 = 1'b1;
    @(negedge clk);
    rst = 1'b0; or8 = 1'b0; or16 = 1'b0;
    check("rst_in_ready", 64'(rdy_obs), 64'd1);
    check("rst_valid", 64'(vld_obs), 64'd0);
    check("rst_count", cnt_obs, 64'd0);
`ifdef COUNT_LZ_EN
    check("rst_lz", lz_obs, 64'd0);
`endif
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (vld_obs) seen++; end
    check("no_stale_valid", 64'(seen), 64'd0);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_in_ready8", 64'(ir8), 64'd1);
    check("reset_valid8", 64'(ov8), 64'd0);
    check("reset_count8", 64'(c8), 64'd0);
    check("reset_in_ready16", 64'(ir16), 64'd1);
    check("reset_valid16", 64'(ov16), 64'd0);
    check("reset_count16", 64'(c16), 64'd0);
    run(1'b0, 16'h000A, 1'b0, 0);
    run(1'b0, 16'h0000, 1'b0, 1);
    run(1'b0, 16'h00FF, 1'b0, 0);
    run(1'b0, 16'h00FF, 1'b1, 0);
    run(1'b0, 16'h000A, 1'b1, 5);
    run(1'b0, 16'h0080, 1'b0, 0);
    reset_mid(1'b0, 2);
    run(1'b0, 16'h000F, 1'b0, 0);
    run(1'b1, 16'h00F1, 1'b0, 2);
    run(1'b1, 16'hFFFF, 1'b1, 0);
    run(1'b1, 16'h0000, 1'b0, 0);
    run(1'b1, 16'h8001, 1'b1, 0);
    reset_mid(1'b1, 6);
    for (int k = 0; k < 40; k++)
      run(1'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/count_bits_seq.md
COUNT_BITS_SEQ -- requirements
Module: count_bits_seq

Interface
REQ-001 Parameter DATA_W, default 8, shall set the input word width in bits; legal range 2..64.
REQ-002 Parameter BPC, default 1, shall set bits examined per clock; must divide DATA_W exactly.
REQ-003 Derived constant CW = $clog2(DATA_W+1) shall set the width of every count output.
REQ-004 Port clk, input, 1 bit, shall be the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit, shall be the synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit, shall mark in_data and in_mode as valid.
REQ-007 Port in_ready, output, 1 bit, shall indicate the block can accept a word.
REQ-008 Port in_data, input, DATA_W bits, shall carry the word to be counted.
REQ-009 Port in_mode, input, 1 bit, shall select the count target: 0 counts zeros, 1 counts ones.
REQ-010 Port out_valid, output, 1 bit, shall mark out_count (and out_lz) as valid.
REQ-011 Port out_ready, input, 1 bit, shall indicate the consumer accepts the result.
REQ-012 Port out_count, output, CW bits, shall carry the number of bits equal to the selected target.
REQ-013 Port out_lz, output, CW bits, present only with COUNT_LZ_EN, shall carry the leading-zero count of the word.

Function
REQ-014 The block shall implement a three-state FSM: IDLE, SCAN, DONE.
REQ-015 In IDLE, in_ready shall be 1 and out_valid shall be 0.
REQ-016 An input handshake shall occur on a rising edge with in_valid=1 and in_ready=1: data and mode registered, count and bit index cleared, FSM to SCAN.
REQ-017 In SCAN, in_ready shall be 0; each cycle, BPC bits shall be examined starting from bit 0, LSB first, and matches added to the count.
REQ-018 SCAN shall last exactly DATA_W/BPC cycles, then FSM to DONE; out_valid shall rise DATA_W/BPC cycles after the accepting edge.
REQ-019 In DONE, out_valid shall be 1 and out_count (and out_lz) shall hold stable until the output handshake.
REQ-020 An output handshake (out_valid=1 and out_ready=1 on a rising edge) shall return the FSM to IDLE; there is no same-cycle re-accept, so minimum throughput is one word per DATA_W/BPC+2 cycles.
REQ-021 in_data/in_mode changes outside the input handshake shall not affect the result in progress.
REQ-022 Count arithmetic shall be unsigned CW bits; the maximum value DATA_W (all bits match) shall be represented without overflow.
REQ-023 out_count shall read 0 whenever out_valid is 0.

Reset
REQ-024 rst=1 on a rising edge shall force IDLE, in_ready=1, out_valid=0, out_count=0 and out_lz=0, overriding any handshake in the same cycle.
REQ-025 Reset asserted during SCAN or DONE shall discard the word in progress; no out_valid shall follow for it.

Configuration
REQ-026 Macro COUNT_LZ_EN, when defined, shall add out_lz: leading zeros counted from bit DATA_W-1 down to the first 1, independent of in_mode, equal to DATA_W for an all-zero word, computed during SCAN with no added latency.
REQ-027 Without COUNT_LZ_EN, the out_lz port and its logic shall be absent; all other behaviour is identical.

Verification
REQ-028 DATA_W=8, BPC=1, in_data=8'b00001010, in_mode=0 -> out_valid 8 cycles after accept, out_count=6, out_lz=4.
REQ-029 in_data=8'h00, in_mode=0 -> out_count=8, out_lz=8; in_data=8'hFF, in_mode=0 -> out_count=0, out_lz=0.
REQ-030 in_data=8'b00001010, in_mode=1 -> out_count=2; with out_ready held 0 for 5 cycles, out_count stays 2 and in_ready stays 0 throughout.
REQ-031 rst=1 pulsed at SCAN cycle 3 -> next cycle in_ready=1, out_valid=0; a new word 8'h0F (in_mode=0) then yields out_count=4.
REQ-032 DATA_W=16, BPC=4, in_data=16'h00F1, in_mode=0 -> out_valid 4 cycles after accept, out_count=11, out_lz=8.
